// File: rtl/uni_shift_reg_n_pkg.sv
// ---------------------------------------------------------------------------
// uni_shift_pkg
// Shared definitions for the universal shift register slice:
//   mode_e      - 3-bit operation select encodings
//   state_e     - burst controller states
//   isBurstMode - true for the modes a burst may step through
// ---------------------------------------------------------------------------
package uni_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Hold, load and the reserved code make no sense repeated, so a start
  // request with one of them is treated as an ordinary single cycle.
  function automatic logic isBurstMode(mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/uni_shift_reg_n_if.sv
// ---------------------------------------------------------------------------
// uni_shift_reg_n_if
// Bundles the control, data and status signals of uni_shift_reg_n.
//   master : drives en/sel/serial ins/parallel_in/start/amount, reads status
//   slave  : the shift register itself
// ---------------------------------------------------------------------------
interface uni_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);

  logic             en;
  logic [2:0]       sel;
  logic             shift_r_in;
  logic             shift_l_in;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] parallel_out;
  logic             shift_r_out;
  logic             shift_l_out;
  logic             busy;
  logic             done;

  modport master (
    output en, sel, shift_r_in, shift_l_in, parallel_in, start, amount,
    input  parallel_out, shift_r_out, shift_l_out, busy, done
  );

  modport slave (
    input  en, sel, shift_r_in, shift_l_in, parallel_in, start, amount,
    output parallel_out, shift_r_out, shift_l_out, busy, done
  );

endinterface

// File: rtl/uni_shift_reg_n_step.sv
// ---------------------------------------------------------------------------
// uni_shift_step
// Pure combinational next-value function of the register.
//   i_mode      operation to apply
//   i_value     current register contents
//   i_loadData  data used by MODE_LOAD
//   i_shiftRIn  serial bit entering the MSB on a logical right shift
//   i_shiftLIn  serial bit entering the LSB on a left shift
//   o_next      value the register takes on the next enabled edge
// ---------------------------------------------------------------------------
module uni_shift_step
  import uni_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_loadData,
  input  logic             i_shiftRIn,
  input  logic             i_shiftLIn,
  output logic [WIDTH-1:0] o_next
);

  // Hold and the reserved code both fall through to the default.
  always_comb begin
    o_next = i_value;
    case (i_mode)
      MODE_SHR:  o_next = {i_shiftRIn, i_value[WIDTH-1:1]};
      MODE_SHL:  o_next = {i_value[WIDTH-2:0], i_shiftLIn};
      MODE_LOAD: o_next = i_loadData;
      MODE_ROR:  o_next = {i_value[0], i_value[WIDTH-1:1]};
      MODE_ROL:  o_next = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
      MODE_ASR:  o_next = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
      default:   o_next = i_value;
    endcase
  end

endmodule

// File: rtl/uni_shift_reg_n.sv
// ---------------------------------------------------------------------------
// uni_shift_reg_n
// WIDTH-bit universal shift register with a multi-step burst controller.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  uni_shift_reg_n_if.slave: en, sel, serial ins, parallel_in, start,
//        amount in; parallel_out, shift_r_out, shift_l_out, busy, done out
// In IDLE the selected operation runs every enabled edge. A start with a
// shift/rotate mode latches the mode and steps it min(amount, WIDTH) times,
// then pulses done for one cycle.
// ---------------------------------------------------------------------------
module uni_shift_reg_n
  import uni_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst,
  uni_shift_reg_n_if.slave bus
);

  // Counter must hold WIDTH itself; amount is widened so the clamp compare
  // works even when AMT_W is overridden narrower or wider than the counter.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CMP_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;

  state_e           r_state;
  state_e           w_stateNext;
  mode_e            r_mode;
  mode_e            w_modeNext;
  mode_e            w_stepMode;
  mode_e            w_selMode;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic [CNT_W-1:0] w_clamped;
  logic [CMP_W-1:0] w_amtExt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_stepData;
  logic             w_burstReq;

  assign w_selMode  = mode_e'(bus.sel);
  assign w_amtExt   = CMP_W'(bus.amount);
  assign w_clamped  = (w_amtExt > CMP_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(w_amtExt);
  assign w_burstReq = bus.start && isBurstMode(w_selMode);

  // The start edge itself changes no data (step mode stays HOLD); DONE also
  // holds the data so the burst result is visible alongside the done pulse.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_modeNext  = r_mode;
    w_stepMode  = MODE_HOLD;
    case (r_state)
      IDLE: begin
        if (w_burstReq) begin
          w_modeNext  = w_selMode;
          w_countNext = w_clamped;
          w_stateNext = (w_clamped == '0) ? DONE : BUSY;
        end else begin
          w_stepMode = w_selMode;
        end
      end
      BUSY: begin
        w_stepMode  = r_mode;
        w_countNext = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  uni_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mode    (w_stepMode),
    .i_value   (r_data),
    .i_loadData(bus.parallel_in),
    .i_shiftRIn(bus.shift_r_in),
    .i_shiftLIn(bus.shift_l_in),
    .o_next    (w_stepData)
  );

  // en low freezes data, state, counter and latched mode together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_HOLD;
      r_count <= '0;
      r_data  <= '0;
    end else if (bus.en) begin
      r_state <= w_stateNext;
      r_mode  <= w_modeNext;
      r_count <= w_countNext;
      r_data  <= w_stepData;
    end
  end

  assign bus.parallel_out = r_data;
  assign bus.shift_r_out  = r_data[0];
  assign bus.shift_l_out  = r_data[WIDTH-1];
  assign bus.busy         = (r_state == BUSY);
  assign bus.done         = (r_state == DONE);

endmodule

// File: doc/uni_shift_reg_n.md
UNI_SHIFT_REG_N -- requirements
Module: uni_shift_reg_n

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2 to 64.
REQ-002 Parameter: AMT_W, default $clog2(WIDTH)+1, width of the burst-amount port.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 en  input  1  clock enable; low freezes the register, FSM and counter.
REQ-006 sel  input  3  mode: 000 hold, 001 shift right, 010 shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 hold (reserved).
REQ-007 shift_r_in  input  1  serial input into the MSB on a right shift.
REQ-008 shift_l_in  input  1  serial input into the LSB on a left shift.
REQ-009 parallel_in  input  WIDTH  load data.
REQ-010 start  input  1  request a multi-step burst in the mode given by sel.
REQ-011 amount  input  AMT_W  burst step count.
REQ-012 parallel_out  output  WIDTH  register contents.
REQ-013 shift_r_out  output  1  combinational parallel_out[0].
REQ-014 shift_l_out  output  1  combinational parallel_out[WIDTH-1].
REQ-015 busy  output  1  high while a burst is stepping.
REQ-016 done  output  1  single-cycle pulse when a burst completes.

Function
REQ-017 Shift right: out <= {shift_r_in, out[WIDTH-1:1]}.
REQ-018 Shift left: out <= {out[WIDTH-2:0], shift_l_in}.
REQ-019 Rotate right and rotate left: the bit leaving one end enters the other end; serial inputs are ignored.
REQ-020 Arithmetic shift right: the MSB is replicated; shift_r_in is ignored.
REQ-021 The FSM has three states: IDLE, BUSY and DONE.
REQ-022 In IDLE with start low, the sel operation executes on every enabled edge.
REQ-023 In IDLE with start high and sel in {001,010,100,101,110}, that edge performs no data change.
REQ-024 On that edge the FSM latches sel, loads the step counter with min(amount, WIDTH), and enters BUSY.
REQ-025 If the clamped amount is 0, the FSM goes to DONE instead of BUSY.
REQ-026 In IDLE with start high and sel in {000,011,111}, start is ignored and sel executes as a normal cycle.
REQ-027 In BUSY, each enabled edge performs one step of the latched mode.
REQ-028 During BUSY, serial inputs are sampled live on every step.
REQ-029 During BUSY, sel, start, amount and parallel_in are ignored.
REQ-030 After the last step, the FSM enters DONE; busy is high for exactly N enabled cycles, where N is the clamped count.
REQ-031 DONE lasts one cycle with done=1 and returns to IDLE.
REQ-032 A start in DONE is ignored.
REQ-033 A DONE state with en low holds until en is high.
REQ-034 busy and done are registered state decodes; they are never high together.
REQ-035 Data update latency is one clock edge; there is no combinational path from inputs to parallel_out.

Reset
REQ-036 On rst high, immediately: parallel_out=0, busy=0, done=0, FSM=IDLE, counter=0, latched mode=000.
REQ-037 A reset asserted mid-burst aborts the burst without a done pulse.
REQ-038 After reset releases, the block responds on the first rising edge.

Structure
REQ-039 A shared package uni_shift_pkg holds the mode encodings (MODE_HOLD ... MODE_ASR) and the FSM state typedef.
REQ-040 The next-value datapath is one combinational sub-module, uni_shift_step (inputs: mode, value, serial ins; output: next value).
REQ-041 Both IDLE and BUSY paths use uni_shift_step.

Verification (WIDTH=4)
REQ-042 Load, then shift right:
- load 1001, then sel=001 with shift_r_in=1 -> 1100.
- then sel=010 with shift_l_in=1 -> 1001.
REQ-043 Rotate and arithmetic shift:
- 1001 rotate left -> 0011.
- 1001 rotate right -> 1100.
- 1001 ASR -> 1100.
- 0110 ASR -> 0011.
REQ-044 Burst: from 1001, start with sel=010, amount=3, shift_l_in=0:
- values 0010, 0100, 1000;
- busy high 3 cycles;
- done one cycle;
- then hold.
REQ-045 Clamp and zero-amount:
- amount=7, rotate right from 1001 -> 4 steps, ends at 1001, done pulses.
- amount=0 -> no change, done pulses one cycle after start.
REQ-046 en low for 2 cycles mid-burst -> value and busy frozen; burst resumes with the correct remaining steps.
REQ-047 rst pulse mid-burst, asynchronous to clk -> immediate 0000, busy=0, no done pulse.
